// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Provides the FSM state encoding and the default operand width.
package serial_subtractor_pkg;

   localparam int SS_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: diff = a - b - borrow_in.
// Ports: a, b, borrow_in in; diff, borrow_out out.
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic borrow_in,
   output logic diff,
   output logic borrow_out
);

   assign diff       = a ^ b ^ borrow_in;
   assign borrow_out = (~a & b) | (~a & borrow_in) | (b & borrow_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - borrow_in, LSB first, one bit per clock.
// Ports: valid/ready operand input (a, b, borrow_in), valid/ready result output (diff, borrow_out, zero).
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int WIDTH = SS_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             borrow_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
   output logic             zero
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_e           state_q;
   logic [WIDTH-1:0] a_sh_q;
   logic [WIDTH-1:0] b_sh_q;
   logic [WIDTH-1:0] dsh_q;
   logic [WIDTH-1:0] dsh_d;
   logic [WIDTH-1:0] diff_q;
   logic [CW-1:0]    cnt_q;
   logic             brw_q;
   logic             bo_q;
   logic             zero_q;
   logic             cell_d;
   logic             cell_b;

   full_subtractor u_cell (
      .a          (a_sh_q[0]),
      .b          (b_sh_q[0]),
      .borrow_in  (brw_q),
      .diff       (cell_d),
      .borrow_out (cell_b)
   );

   // Result enters at the MSB so bit i lands in position i after WIDTH shifts.
   generate
      if (WIDTH == 1) begin : g_w1
         assign dsh_d = cell_d;
      end else begin : g_wn
         assign dsh_d = {cell_d, dsh_q[WIDTH-1:1]};
      end
   endgenerate

   assign in_ready   = (state_q == IDLE) && rst_n;
   assign out_valid  = (state_q == DONE);
   assign diff       = diff_q;
   assign borrow_out = bo_q;
   assign zero       = zero_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         dsh_q   <= '0;
         diff_q  <= '0;
         cnt_q   <= '0;
         brw_q   <= 1'b0;
         bo_q    <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_sh_q  <= a;
                  b_sh_q  <= b;
                  brw_q   <= borrow_in;
                  cnt_q   <= '0;
                  dsh_q   <= '0;
                  state_q <= SHIFT;
               end
            end
            SHIFT: begin
               dsh_q  <= dsh_d;
               a_sh_q <= a_sh_q >> 1;
               b_sh_q <= b_sh_q >> 1;
               brw_q  <= cell_b;
               if (cnt_q == LAST) begin
                  diff_q  <= dsh_d;
                  bo_q    <= cell_b;
                  zero_q  <= ~|dsh_d;
                  state_q <= DONE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=8 and WIDTH=1.
// Scoreboard queues hold expected results from an arithmetic model.
module tb_serial_subtractor;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   logic       iv8, ir8, ov8, or8, bi8, bo8, z8;
   logic [7:0] a8, b8, d8;

   logic iv1, ir1, ov1, or1, bi1, bo1, z1;
   logic a1, b1, d1;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      logic [7:0] d;
      logic       bo;
      logic       z;
   } exp_t;

   exp_t q8[$];
   exp_t q1[$];

   serial_subtractor #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(iv8), .in_ready(ir8),
      .a(a8), .b(b8), .borrow_in(bi8),
      .out_valid(ov8), .out_ready(or8),
      .diff(d8), .borrow_out(bo8), .zero(z8)
   );

   serial_subtractor #(.WIDTH(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(iv1), .in_ready(ir1),
      .a(a1), .b(b1), .borrow_in(bi1),
      .out_valid(ov1), .out_ready(or1),
      .diff(d1), .borrow_out(bo1), .zero(z1)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input int w, input logic [7:0] a,
                                  input logic [7:0] b, input logic bi);
      logic [8:0] t;
      exp_t       e;
      t = {1'b0, a} - {1'b0, b} - {8'd0, bi};
      e.bo = t[8];
      e.d  = (w == 8) ? t[7:0] : {7'd0, t[0]};
      e.z  = (e.d == 8'd0);
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send8(input logic [7:0] a, input logic [7:0] b,
                        input logic bi);
      int n = 0;
      while (!ir8 && n < 50) begin tick(); n++; end
      check("in_ready8_wait", ir8, 1);
      a8 = a; b8 = b; bi8 = bi; iv8 = 1'b1;
      tick();
      iv8 = 1'b0;
      a8 = 8'($urandom); b8 = 8'($urandom); bi8 = 1'($urandom);
      q8.push_back(model(8, a, b, bi));
   endtask

   task automatic recv8(input string tag, input int lat0, input int hold);
      int   lat = lat0;
      exp_t e;
      or8 = (hold == 0);
      while (!ov8 && lat < 40) begin tick(); lat++; end
      check({tag, "_lat"}, lat, 8);
      if (q8.size() == 0) begin
         check({tag, "_sb_empty"}, 1, 0);
         return;
      end
      e = q8.pop_front();
      check({tag, "_diff"}, d8, e.d);
      check({tag, "_bo"}, bo8, e.bo);
      check({tag, "_zero"}, z8, e.z);
      for (int i = 0; i < hold; i++) begin
         tick();
         check({tag, "_hold_ov"}, ov8, 1);
         check({tag, "_hold_ir"}, ir8, 0);
         check({tag, "_hold_diff"}, d8, e.d);
         check({tag, "_hold_bo"}, bo8, e.bo);
         check({tag, "_hold_z"}, z8, e.z);
      end
      or8 = 1'b1;
      tick();
      check({tag, "_post_ir"}, ir8, 1);
      check({tag, "_post_ov"}, ov8, 0);
   endtask

   task automatic run1(input logic a, input logic b, input logic bi);
      int   lat = 0;
      exp_t e;
      or1 = 1'b1;
      check("w1_ready", ir1, 1);
      a1 = a; b1 = b; bi1 = bi; iv1 = 1'b1;
      tick();
      iv1 = 1'b0;
      q1.push_back(model(1, {7'd0, a}, {7'd0, b}, bi));
      while (!ov1 && lat < 10) begin tick(); lat++; end
      check("w1_lat", lat, 1);
      e = q1.pop_front();
      check("w1_diff", d1, e.d[0]);
      check("w1_bo", bo1, e.bo);
      tick();
      check("w1_post_ov", ov1, 0);
   endtask

   initial begin
      int extra;
      rst_n = 1'b0;
      iv8 = 0; or8 = 0; a8 = 0; b8 = 0; bi8 = 0;
      iv1 = 0; or1 = 0; a1 = 0; b1 = 0; bi1 = 0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ov", ov8, 0);
      check("rst_ir", ir8, 0);
      check("rst_diff", d8, 0);
      check("rst_bo", bo8, 0);
      check("rst_zero", z8, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("rst_rel_ir", ir8, 1);

      // Basic and boundary operand patterns.
      send8(8'd100, 8'd37, 1'b0); recv8("t1", 0, 0);
      send8(8'd5, 8'd9, 1'b0);    recv8("t2a", 0, 0);
      send8(8'd0, 8'd0, 1'b1);    recv8("t2b", 0, 0);
      send8(8'd77, 8'd77, 1'b0);  recv8("t2c", 0, 0);
      send8(8'd255, 8'd0, 1'b1);  recv8("t2d", 0, 0);
      send8(8'd0, 8'd255, 1'b0);  recv8("t2e", 0, 0);

      // Backpressure.
      send8(8'd200, 8'd56, 1'b0); recv8("t3", 0, 5);

      // Busy rejection: a second request during SHIFT is ignored.
      send8(8'd10, 8'd3, 1'b0);
      tick(); tick();
      a8 = 8'd200; b8 = 8'd1; iv8 = 1'b1;
      tick();
      iv8 = 1'b0;
      recv8("t4", 3, 0);
      extra = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (ov8) extra++;
      end
      check("t4_no_second", extra, 0);

      // Reset in the middle of SHIFT discards the in-flight result.
      send8(8'd123, 8'd45, 1'b0);
      void'(q8.pop_back());
      tick(); tick(); tick();
      rst_n = 1'b0;
      #1;
      check("t5_ov", ov8, 0);
      check("t5_diff", d8, 0);
      check("t5_ir", ir8, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      send8(8'd50, 8'd20, 1'b0); recv8("t5", 0, 0);

      // WIDTH=1 truth table.
      for (int k = 0; k < 8; k++) begin
         logic [2:0] v;
         v = 3'(k);
         run1(v[2], v[1], v[0]);
      end

      check("sb8_empty", q8.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
